fetch_stage: RTL and testbench

- IF stage of the pipelined RV32I core. Owns the PC register and next-PC selection, and drives the address of the combinational-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register that feeds decode.
- Handles the stall, flush and branch/jump redirect requests raised by the hazard unit and EX stage.
- Detects misaligned redirect targets and keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage_if_id_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: widths, FSM encodings and constants.
`ifndef I_WIDTH
`define I_WIDTH 32
`endif
`ifndef I_ADD_SIZE
`define I_ADD_SIZE 32
`endif

package fetch_stage_pkg;

  localparam int I_WIDTH    = `I_WIDTH;
  localparam int I_ADD_SIZE = `I_ADD_SIZE;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
  parameter int ADD_SIZE = 32,
  parameter int WIDTH    = 32
);
  logic                i_stall;
  logic                i_flush;
  logic                i_redirect;
  logic [ADD_SIZE-1:0] i_redirect_pc;
  logic [ADD_SIZE-1:0] o_imem_add;
  logic [WIDTH-1:0]    i_imem_instr;
  logic [WIDTH-1:0]    o_id_instr;
  logic [ADD_SIZE-1:0] o_id_pc;
  logic [ADD_SIZE-1:0] o_id_pc_plus4;
  logic                o_id_valid;
  logic                o_fetch_fault;
  logic [31:0]         o_fetch_count;

  modport master (
    output i_stall, i_flush, i_redirect, i_redirect_pc, i_imem_instr,
    input  o_imem_add, o_id_instr, o_id_pc, o_id_pc_plus4, o_id_valid,
           o_fetch_fault, o_fetch_count
  );

  modport slave (
    input  i_stall, i_flush, i_redirect, i_redirect_pc, i_imem_instr,
    output o_imem_add, o_id_instr, o_id_pc, o_id_pc_plus4, o_id_valid,
           o_fetch_fault, o_fetch_count
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; with neither asserted all fields hold.
module fetch_stage_if_id_reg #(
  parameter int                ADD_SIZE = 32,
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  NOP      = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                bubble_i,
  input  logic [WIDTH-1:0]    instr_i,
  input  logic [ADD_SIZE-1:0] pc_i,
  input  logic [ADD_SIZE-1:0] pc_plus4_i,
  output logic [WIDTH-1:0]    instr_o,
  output logic [ADD_SIZE-1:0] pc_o,
  output logic [ADD_SIZE-1:0] pc_plus4_o,
  output logic                valid_o
);

  logic [WIDTH-1:0]    instr_q,    instr_d;
  logic [ADD_SIZE-1:0] pc_q,       pc_d;
  logic [ADD_SIZE-1:0] pc_plus4_q, pc_plus4_d;
  logic                valid_q,    valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d    = NOP;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, next-PC selection, boot/run/halt FSM and fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                   ADD_SIZE = I_ADD_SIZE,
  parameter int                   WIDTH    = I_WIDTH,
  parameter logic [ADD_SIZE-1:0]  RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WIDTH-1:0]     NOP      = NOP_INSTR
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_stage_if.slave  bus
);

  logic [1:0]          state_q, state_d;
  logic [ADD_SIZE-1:0] pc_q,    pc_d;
  logic                fault_q, fault_d;
  logic [31:0]         count_q, count_d;
  logic [ADD_SIZE-1:0] pc_plus4;
  logic                id_load;
  logic                id_bubble;

  assign pc_plus4 = pc_q + ADD_SIZE'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    count_d   = count_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.i_redirect) begin
          id_bubble = 1'b1;
          if (is_word_aligned(bus.i_redirect_pc[1:0])) begin
            pc_d = bus.i_redirect_pc;
          end else begin
            // Misaligned target: keep the PC so the faulting context stays visible.
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        end else begin
          if (bus.i_flush) begin
            id_bubble = 1'b1;
          end else if (!bus.i_stall) begin
            id_load = 1'b1;
            count_d = count_q + 32'd1;
          end
          if (!bus.i_stall) begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: id_bubble = 1'b1;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  fetch_stage_if_id_reg #(
    .ADD_SIZE (ADD_SIZE),
    .WIDTH    (WIDTH),
    .NOP      (NOP)
  ) u_if_id_reg (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (id_load),
    .bubble_i   (id_bubble),
    .instr_i    (bus.i_imem_instr),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (bus.o_id_instr),
    .pc_o       (bus.o_id_pc),
    .pc_plus4_o (bus.o_id_pc_plus4),
    .valid_o    (bus.o_id_valid)
  );

  assign bus.o_imem_add    = pc_q;
  assign bus.o_fetch_fault = fault_q;
  assign bus.o_fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_stage_if #(.ADD_SIZE(32), .WIDTH(32)) bus ();

  fetch_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words 0x11/0x22/0x33 at 0/4/8; elsewhere a tag derived from the address.
  always_comb begin
    case (bus.o_imem_add)
      32'h0:   bus.i_imem_instr = 32'h0000_0011;
      32'h4:   bus.i_imem_instr = 32'h0000_0022;
      32'h8:   bus.i_imem_instr = 32'h0000_0033;
      default: bus.i_imem_instr = 32'h1000_0000 | bus.o_imem_add;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    bus.i_stall       = st;
    bus.i_flush       = fl;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("rst_instr", bus.o_id_instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, bus.o_id_valid}, 32'd0);
    chk("rst_pc", bus.o_id_pc, 32'h0);
    chk("rst_pc4", bus.o_id_pc_plus4, 32'h0);
    chk("rst_fault", {31'd0, bus.o_fetch_fault}, 32'd0);
    chk("rst_count", bus.o_fetch_count, 32'd0);
    chk("rst_add", bus.o_imem_add, 32'h0);

    // BOOT cycle, with redirect asserted to show it is ignored.
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("boot_valid", {31'd0, bus.o_id_valid}, 32'd0);
    chk("boot_add", bus.o_imem_add, 32'h0);
    chk("boot_count", bus.o_fetch_count, 32'd0);

    step();
    chk("f0_instr", bus.o_id_instr, 32'h11);
    chk("f0_pc", bus.o_id_pc, 32'h0);
    chk("f0_pc4", bus.o_id_pc_plus4, 32'h4);
    chk("f0_count", bus.o_fetch_count, 32'd1);
    step();
    chk("f1_instr", bus.o_id_instr, 32'h22);
    chk("f1_pc", bus.o_id_pc, 32'h4);
    chk("f1_count", bus.o_fetch_count, 32'd2);
    chk("f1_add", bus.o_imem_add, 32'h8);

    // Stall three cycles while PC=8.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_add", i), bus.o_imem_add, 32'h8);
      chk($sformatf("stall%0d_instr", i), bus.o_id_instr, 32'h22);
      chk($sformatf("stall%0d_count", i), bus.o_fetch_count, 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("f2_instr", bus.o_id_instr, 32'h33);
    chk("f2_pc", bus.o_id_pc, 32'h8);
    chk("f2_count", bus.o_fetch_count, 32'd3);
    chk("f2_add", bus.o_imem_add, 32'hC);
    step();
    chk("f3_instr", bus.o_id_instr, 32'h1000_000C);
    chk("f3_add", bus.o_imem_add, 32'h10);

    // Redirect to 0x40 at PC=0x10.
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_add", bus.o_imem_add, 32'h40);
    chk("rd_valid", {31'd0, bus.o_id_valid}, 32'd0);
    chk("rd_bub_pc", bus.o_id_pc, 32'h10);
    chk("rd_bub_pc4", bus.o_id_pc_plus4, 32'h14);
    chk("rd_count", bus.o_fetch_count, 32'd4);
    step();
    chk("rd1_pc", bus.o_id_pc, 32'h40);
    chk("rd1_valid", {31'd0, bus.o_id_valid}, 32'd1);
    chk("rd1_instr", bus.o_id_instr, 32'h1000_0040);
    chk("rd1_count", bus.o_fetch_count, 32'd5);

    // Flush + stall: bubble, PC holds.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("fs_instr", bus.o_id_instr, 32'h0000_0013);
    chk("fs_valid", {31'd0, bus.o_id_valid}, 32'd0);
    chk("fs_add", bus.o_imem_add, 32'h44);
    chk("fs_count", bus.o_fetch_count, 32'd5);

    // Redirect + stall: redirect wins.
    drive(1'b1, 1'b0, 1'b1, 32'h80);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rs_add", bus.o_imem_add, 32'h80);
    chk("rs_valid", {31'd0, bus.o_id_valid}, 32'd0);
    step();
    chk("rs1_pc", bus.o_id_pc, 32'h80);
    chk("rs1_count", bus.o_fetch_count, 32'd6);

    // Wrap at top of address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wr_add", bus.o_imem_add, 32'hFFFF_FFFC);
    step();
    chk("wr1_add", bus.o_imem_add, 32'h0);
    chk("wr1_pc", bus.o_id_pc, 32'hFFFF_FFFC);
    chk("wr1_pc4", bus.o_id_pc_plus4, 32'h0);
    chk("wr1_count", bus.o_fetch_count, 32'd7);
    step();
    chk("wr2_instr", bus.o_id_instr, 32'h11);
    chk("wr2_add", bus.o_imem_add, 32'h4);
    chk("wr2_count", bus.o_fetch_count, 32'd8);

    // Misaligned redirect at PC=4 -> HALT.
    drive(1'b0, 1'b0, 1'b1, 32'h42);
    step();
    chk("mis_fault", {31'd0, bus.o_fetch_fault}, 32'd1);
    chk("mis_add", bus.o_imem_add, 32'h4);
    chk("mis_valid", {31'd0, bus.o_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("halt%0d_add", i), bus.o_imem_add, 32'h4);
      chk($sformatf("halt%0d_valid", i), {31'd0, bus.o_id_valid}, 32'd0);
      chk($sformatf("halt%0d_count", i), bus.o_fetch_count, 32'd8);
      chk($sformatf("halt%0d_fault", i), {31'd0, bus.o_fetch_fault}, 32'd1);
      chk($sformatf("halt%0d_instr", i), bus.o_id_instr, 32'h0000_0013);
    end

    // Reset mid-HALT with redirect and stall still asserted.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    step();
    chk("hr_fault", {31'd0, bus.o_fetch_fault}, 32'd0);
    chk("hr_add", bus.o_imem_add, 32'h0);
    chk("hr_count", bus.o_fetch_count, 32'd0);
    chk("hr_pc", bus.o_id_pc, 32'h0);
    chk("hr_valid", {31'd0, bus.o_id_valid}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("hr_boot_valid", {31'd0, bus.o_id_valid}, 32'd0);
    step();
    chk("hr_f0_instr", bus.o_id_instr, 32'h11);
    chk("hr_f0_count", bus.o_fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
